// File: rtl/qmult_seq.sv
// Sequential shift-add multiplier for sign-magnitude Q-format words.
// One add per cycle over N-1 iterations; saturates on magnitude overflow.
module qmult_seq #(
   parameter int Q = 12,
   parameter int N = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_multiplicand,
   input  logic [N-1:0] i_multiplier,
   input  logic         i_start,
   output logic [N-1:0] o_result_out,
   output logic         o_complete,
   output logic         o_overflow,
   output logic         o_busy
);

   localparam int CW = $clog2(N);
   localparam int PW = 2*N-2;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t          state_q;
   logic [PW-1:0]   a_q;
   logic [N-2:0]    b_q;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   acc_d;
   logic [CW-1:0]   cnt_q;
   logic            sign_q;
   logic [N-1:0]    result_q;
   logic            complete_q;
   logic            ovf_q;
   logic            ovf_d;
   logic [N-2:0]    mag_d;

   assign acc_d = b_q[0] ? acc_q + a_q : acc_q;

   // Anything above the integer range of the output word means saturation.
   assign ovf_d = |acc_q[PW-1:Q+N-1];
   assign mag_d = ovf_d ? '1 : acc_q[Q+N-2:Q];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         result_q   <= '0;
         complete_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         complete_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  a_q     <= {{(N-1){1'b0}}, i_multiplicand[N-2:0]};
                  b_q     <= i_multiplier[N-2:0];
                  sign_q  <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= MUL;
               end
            end
            MUL: begin
               acc_q <= acc_d;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N-2))
                  state_q <= DONE;
            end
            DONE: begin
               // Zero magnitude always reports a positive sign.
               result_q   <= {sign_q & (|mag_d), mag_d};
               ovf_q      <= ovf_d;
               complete_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_result_out = result_q;
   assign o_complete   = complete_q;
   assign o_overflow   = ovf_q;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_qmult_seq.sv
// Directed bench for qmult_seq: vector table plus handshake and reset sequences.
module tb_qmult_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mcand, mplier;
   logic        start;
   logic [15:0] result;
   logic        complete, ovf, busy;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   qmult_seq #(.Q(12), .N(16)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_multiplicand (mcand),
      .i_multiplier   (mplier),
      .i_start        (start),
      .o_result_out   (result),
      .o_complete     (complete),
      .o_overflow     (ovf),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_r;
      logic        exp_ov;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch one op and wait (bounded) for its completion pulse.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busyc, output logic done);
      int e0;
      @(negedge clk); mcand = a; mplier = b; start = 1'b1;
      @(posedge clk); #1; e0 = cyc; busyc = busy ? 1 : 0; done = 1'b0;
      @(negedge clk); start = 1'b0;
      lat = 0;
      while (lat < 40 && !done) begin
         @(posedge clk); #1;
         lat = cyc - e0;
         if (complete) done = 1'b1;
         else if (busy) busyc++;
      end
   endtask

   vec_t vecs[8];
   int   lat, busyc, e0, ncomp, t1, t2;
   logic done;

   initial begin
      vecs[0] = '{16'h1800, 16'h2000, 16'h3000, 1'b0};
      vecs[1] = '{16'h9000, 16'h2800, 16'hA800, 1'b0};
      vecs[2] = '{16'h9000, 16'hA800, 16'h2800, 1'b0};
      vecs[3] = '{16'h8001, 16'h0001, 16'h0000, 1'b0};
      vecs[4] = '{16'h0001, 16'h1800, 16'h0001, 1'b0};
      vecs[5] = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1};
      vecs[6] = '{16'hC000, 16'h4000, 16'hFFFF, 1'b1};
      vecs[7] = '{16'h1000, 16'h1000, 16'h1000, 1'b0};

      rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", result, 0);
      chk("reset_complete", complete, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, lat, busyc, done);
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_latency", i), lat, 16);
         chk($sformatf("v%0d_busy_cycles", i), busyc, 16);
         chk($sformatf("v%0d_result", i), result, vecs[i].exp_r);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ov);
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse_width", i), complete, 0);
         chk($sformatf("v%0d_result_hold", i), result, vecs[i].exp_r);
      end

      // Second start 5 cycles into an op must be ignored.
      @(negedge clk); mcand = 16'h1800; mplier = 16'h2000; start = 1'b1;
      @(posedge clk); #1; e0 = cyc;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      mcand = 16'h4000; mplier = 16'h4000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      ncomp = 0; t1 = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (complete) begin
            ncomp++;
            if (ncomp == 1) begin
               t1 = cyc - e0;
               chk("ign_result", result, 16'h3000);
               chk("ign_ovf", ovf, 0);
            end
         end
      end
      chk("ign_completions", ncomp, 1);
      chk("ign_latency", t1, 16);

      // Continuous start: completions every N+1 cycles.
      @(negedge clk); mcand = 16'h1000; mplier = 16'h1000; start = 1'b1;
      ncomp = 0; t1 = 0; t2 = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (complete) begin
            ncomp++;
            if (ncomp == 1) t1 = cyc;
            if (ncomp == 2) t2 = cyc;
         end
      end
      @(negedge clk); start = 1'b0;
      chk("b2b_completions", ncomp, 2);
      chk("b2b_spacing", t2 - t1, 17);
      chk("b2b_result", result, 16'h1000);
      repeat (25) @(posedge clk);

      // Reset 8 cycles after start aborts the op.
      @(negedge clk); mcand = 16'h1800; mplier = 16'h2000; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_result", result, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ovf", ovf, 0);
      chk("rst_mid_complete", complete, 0);
      @(negedge clk); rst = 1'b0;
      ncomp = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (complete) ncomp++;
      end
      chk("rst_mid_no_complete", ncomp, 0);
      do_op(16'h1800, 16'h2000, lat, busyc, done);
      chk("post_rst_done", done, 1);
      chk("post_rst_latency", lat, 16);
      chk("post_rst_result", result, 16'h3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
